// File: rtl/gray_fifo_ctrl_if.sv
// Request/enable/status bundle between the FIFO pointer controller and its users.
// The slave side is the controller. The master side is the producer/consumer plus RAM glue.
interface gray_fifo_ctrl_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  WrReq_in;
  logic                  RdReq_in;
  logic                  WrEn_out;
  logic                  RdEn_out;
  logic [ADDR_WIDTH-1:0] WrAddrGray_out;
  logic [ADDR_WIDTH-1:0] RdAddrGray_out;
  logic [ADDR_WIDTH:0]   Level_out;
  logic                  Full_out;
  logic                  Empty_out;
  logic                  AlmostFull_out;
  logic                  AlmostEmpty_out;
  logic                  Overflow_out;
  logic                  Underflow_out;

  modport slave (
    input  WrReq_in, RdReq_in,
    output WrEn_out, RdEn_out, WrAddrGray_out, RdAddrGray_out, Level_out,
           Full_out, Empty_out, AlmostFull_out, AlmostEmpty_out,
           Overflow_out, Underflow_out
  );

  modport master (
    output WrReq_in, RdReq_in,
    input  WrEn_out, RdEn_out, WrAddrGray_out, RdAddrGray_out, Level_out,
           Full_out, Empty_out, AlmostFull_out, AlmostEmpty_out,
           Overflow_out, Underflow_out
  );
endinterface

// File: rtl/gray_fifo_ctrl.sv
// Single-clock FIFO pointer/flag controller.
// It gates requests into RAM enables and keeps binary pointers with registered Gray addresses.
// It also tracks occupancy and raises full/empty, threshold and sticky error flags.
module gray_fifo_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_MARGIN  = 2,
  parameter int AE_MARGIN  = 2
) (
  input logic              Clk,
  input logic              Clear_in,
  gray_fifo_ctrl_if.slave  bus
);

  localparam int LW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [LW-1:0] DEPTH_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] AF_LVL    = LW'(DEPTH - AF_MARGIN);
  localparam logic [LW-1:0] AE_LVL    = LW'(AE_MARGIN);

  logic [ADDR_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
  logic [ADDR_WIDTH-1:0] wr_gray_reg, wr_gray_next;
  logic [ADDR_WIDTH-1:0] rd_gray_reg, rd_gray_next;
  logic [LW-1:0]         level_reg, level_next;
  logic                  full_reg, full_next;
  logic                  empty_reg, empty_next;
  logic                  af_reg, af_next;
  logic                  ae_reg, ae_next;
  logic                  ovf_reg, ovf_next;
  logic                  unf_reg, unf_next;
  logic                  wr_en, rd_en;

  // Requests are gated only by registered flags, so no request reaches a flag combinationally.
  // An empty FIFO never reads and a full one never writes.
  // This gives the simultaneous-request rules at both boundaries.
  always_comb begin
    wr_en = bus.WrReq_in & ~full_reg;
    rd_en = bus.RdReq_in & ~empty_reg;
  end

  // Pointer advance and occupancy update for the accepted operations.
  always_comb begin
    wr_ptr_next = wr_ptr_reg + ADDR_WIDTH'(wr_en);
    rd_ptr_next = rd_ptr_reg + ADDR_WIDTH'(rd_en);
    level_next  = level_reg;
    case ({wr_en, rd_en})
      2'b10:   level_next = level_reg + LW'(1);
      2'b01:   level_next = level_reg - LW'(1);
      default: level_next = level_reg;
    endcase
  end

  // Binary-to-Gray conversion of the post-update pointers; the MSB passes straight through.
  assign wr_gray_next[ADDR_WIDTH-1] = wr_ptr_next[ADDR_WIDTH-1];
  assign rd_gray_next[ADDR_WIDTH-1] = rd_ptr_next[ADDR_WIDTH-1];
  generate
    for (genvar gi = 0; gi < ADDR_WIDTH - 1; gi++) begin : g_gray
      assign wr_gray_next[gi] = wr_ptr_next[gi] ^ wr_ptr_next[gi+1];
      assign rd_gray_next[gi] = rd_ptr_next[gi] ^ rd_ptr_next[gi+1];
    end
  endgenerate

  // Status flags are derived from the next level, so they are valid one cycle after the access.
  always_comb begin
    full_next  = (level_next == DEPTH_LVL);
    empty_next = (level_next == '0);
    af_next    = (level_next >= AF_LVL);
    ae_next    = (level_next <= AE_LVL);
    ovf_next   = ovf_reg | (bus.WrReq_in & full_reg);
    unf_next   = unf_reg | (bus.RdReq_in & empty_reg);
  end

  // State register. Clear discards all contents and overrides any request in the same cycle.
  always_ff @(posedge Clk) begin
    if (Clear_in) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      wr_gray_reg <= '0;
      rd_gray_reg <= '0;
      level_reg   <= '0;
      full_reg    <= 1'b0;
      empty_reg   <= 1'b1;
      af_reg      <= 1'b0;
      ae_reg      <= 1'b1;
      ovf_reg     <= 1'b0;
      unf_reg     <= 1'b0;
    end else begin
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      wr_gray_reg <= wr_gray_next;
      rd_gray_reg <= rd_gray_next;
      level_reg   <= level_next;
      full_reg    <= full_next;
      empty_reg   <= empty_next;
      af_reg      <= af_next;
      ae_reg      <= ae_next;
      ovf_reg     <= ovf_next;
      unf_reg     <= unf_next;
    end
  end

  assign bus.WrEn_out        = wr_en;
  assign bus.RdEn_out        = rd_en;
  assign bus.WrAddrGray_out  = wr_gray_reg;
  assign bus.RdAddrGray_out  = rd_gray_reg;
  assign bus.Level_out       = level_reg;
  assign bus.Full_out        = full_reg;
  assign bus.Empty_out       = empty_reg;
  assign bus.AlmostFull_out  = af_reg;
  assign bus.AlmostEmpty_out = ae_reg;
  assign bus.Overflow_out    = ovf_reg;
  assign bus.Underflow_out   = unf_reg;

endmodule

// File: tb/tb_gray_fifo_ctrl.sv
// Self-checking bench for gray_fifo_ctrl.
// A vector table with hand-derived expectations is applied alongside a scoreboard-fed reference model.
// A hand-written wrap/clear sequence follows.
module tb_gray_fifo_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic Clk = 1'b0;
  logic Clear_in;

  gray_fifo_ctrl_if #(.ADDR_WIDTH(AW)) bus_if();

  gray_fifo_ctrl #(
    .ADDR_WIDTH(AW),
    .AF_MARGIN (2),
    .AE_MARGIN (2)
  ) dut (
    .Clk     (Clk),
    .Clear_in(Clear_in),
    .bus     (bus_if)
  );

  always #5 Clk = ~Clk;

  // Expected register state after one clock edge.
  typedef struct {
    int level; int wg; int rg;
    int full; int empty; int af; int ae; int ovf; int unf;
  } exp_t;

  // Stimulus plus hand-derived expectations; -1 means the field is not checked.
  typedef struct {
    logic clr; logic wr; logic rd;
    int level; int wg; int rg; int full; int af; int ovf; int unf;
  } vec_t;

  exp_t sb_q[$];
  vec_t vt[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state.
  int m_lvl = 0, m_wp = 0, m_rp = 0, m_ovf = 0, m_unf = 0;
  int prev_wg = -1, prev_rg = -1;

  int gseq[16] = '{1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int to_gray(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic add_vec(input logic clr, input logic wr, input logic rd, input int level,
                         input int wg, input int rg, input int full, input int af,
                         input int ovf, input int unf);
    vec_t v;
    v.clr = clr; v.wr = wr; v.rd = rd; v.level = level; v.wg = wg; v.rg = rg;
    v.full = full; v.af = af; v.ovf = ovf; v.unf = unf;
    vt.push_back(v);
  endtask

  // Drive one cycle, check combinational enables, push the model's prediction, compare after the edge.
  task automatic step(input logic clr, input logic wr, input logic rd);
    exp_t e;
    int   aw, ar, cur_wg, cur_rg;
    @(negedge Clk);
    Clear_in        = clr;
    bus_if.WrReq_in = wr;
    bus_if.RdReq_in = rd;
    #1;
    aw = (wr && m_lvl != DEPTH) ? 1 : 0;
    ar = (rd && m_lvl != 0) ? 1 : 0;
    chk("wr_en", bus_if.WrEn_out, aw);
    chk("rd_en", bus_if.RdEn_out, ar);
    if (clr) begin
      m_lvl = 0; m_wp = 0; m_rp = 0; m_ovf = 0; m_unf = 0;
    end else begin
      if (wr && m_lvl == DEPTH) m_ovf = 1;
      if (rd && m_lvl == 0)     m_unf = 1;
      m_lvl = m_lvl + aw - ar;
      m_wp  = (m_wp + aw) % DEPTH;
      m_rp  = (m_rp + ar) % DEPTH;
    end
    e.level = m_lvl; e.wg = to_gray(m_wp); e.rg = to_gray(m_rp);
    e.full = (m_lvl == DEPTH); e.empty = (m_lvl == 0);
    e.af = (m_lvl >= DEPTH - 2); e.ae = (m_lvl <= 2);
    e.ovf = m_ovf; e.unf = m_unf;
    sb_q.push_back(e);
    @(posedge Clk);
    #1;
    if (sb_q.size() == 0) begin
      n_tests++; n_fail++;
      $display("[TB] FAIL sb_empty: got 0 entries expected 1");
    end else begin
      e = sb_q.pop_front();
      chk("level", bus_if.Level_out, e.level);
      chk("wr_gray", bus_if.WrAddrGray_out, e.wg);
      chk("rd_gray", bus_if.RdAddrGray_out, e.rg);
      chk("full", bus_if.Full_out, e.full);
      chk("empty", bus_if.Empty_out, e.empty);
      chk("almost_full", bus_if.AlmostFull_out, e.af);
      chk("almost_empty", bus_if.AlmostEmpty_out, e.ae);
      chk("overflow", bus_if.Overflow_out, e.ovf);
      chk("underflow", bus_if.Underflow_out, e.unf);
    end
    cur_wg = int'(bus_if.WrAddrGray_out);
    cur_rg = int'(bus_if.RdAddrGray_out);
    if (!clr && prev_wg >= 0) begin
      chk("wr_gray_1bit", ($countones(cur_wg ^ prev_wg) <= 1), 1);
      chk("rd_gray_1bit", ($countones(cur_rg ^ prev_rg) <= 1), 1);
    end
    prev_wg = cur_wg;
    prev_rg = cur_rg;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Clear_in        = 1'b0;
    bus_if.WrReq_in = 1'b0;
    bus_if.RdReq_in = 1'b0;

    // Clear, then fill to full with the reference Gray sequence.
    add_vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 16; k++)
      add_vec(0, 1, 0, k, gseq[k-1], 0, (k == 16), (k >= 14), 0, 0);
    // Writes while full are rejected and set the overflow flag.
    for (int k = 0; k < 3; k++)
      add_vec(0, 1, 0, 16, 0, 0, 1, 1, 1, 0);
    // Drain to level 5.
    for (int k = 1; k <= 11; k++)
      add_vec(0, 0, 1, 16 - k, 0, (k == 11) ? 14 : -1, 0, (16 - k >= 14), 1, 0);
    // Simultaneous requests mid-range keep the level and advance both addresses.
    for (int k = 1; k <= 4; k++)
      add_vec(0, 1, 1, 5, (k == 4) ? 6 : -1, (k == 4) ? 8 : -1, 0, 0, 1, 0);
    // Drain to empty.
    for (int k = 1; k <= 5; k++)
      add_vec(0, 0, 1, 5 - k, 6, (k == 5) ? 6 : -1, 0, 0, 1, 0);
    // Simultaneous requests while empty: only the write is accepted.
    add_vec(0, 1, 1, 1, 7, 6, 0, 0, 1, 1);

    foreach (vt[i]) begin
      step(vt[i].clr, vt[i].wr, vt[i].rd);
      chk("tbl_level", bus_if.Level_out, vt[i].level);
      if (vt[i].wg >= 0) chk("tbl_wr_gray", bus_if.WrAddrGray_out, vt[i].wg);
      if (vt[i].rg >= 0) chk("tbl_rd_gray", bus_if.RdAddrGray_out, vt[i].rg);
      chk("tbl_full", bus_if.Full_out, vt[i].full);
      chk("tbl_almost_full", bus_if.AlmostFull_out, vt[i].af);
      chk("tbl_overflow", bus_if.Overflow_out, vt[i].ovf);
      chk("tbl_underflow", bus_if.Underflow_out, vt[i].unf);
      $display("[TB] vec %0d clr=%0b wr=%0b rd=%0b level=%0d wg=%h rg=%h", i, vt[i].clr,
               vt[i].wr, vt[i].rd, bus_if.Level_out, bus_if.WrAddrGray_out, bus_if.RdAddrGray_out);
    end

    // 40 ops: 10 writes, 27 simultaneous ops across the pointer wrap, then 3 reads, ending at level 7.
    step(1, 0, 0);
    for (int k = 0; k < 10; k++) step(0, 1, 0);
    for (int k = 0; k < 27; k++) step(0, 1, 1);
    for (int k = 0; k < 3; k++)  step(0, 0, 1);
    chk("wrap_level", bus_if.Level_out, 7);
    chk("wrap_wr_gray", bus_if.WrAddrGray_out, 7);
    chk("wrap_rd_gray", bus_if.RdAddrGray_out, 9);
    $display("[TB] wrap seq level=%0d wg=%h rg=%h", bus_if.Level_out,
             bus_if.WrAddrGray_out, bus_if.RdAddrGray_out);

    // Clear with a write pending: the clear wins and everything returns to reset values.
    step(1, 1, 0);
    chk("clr_level", bus_if.Level_out, 0);
    chk("clr_wr_gray", bus_if.WrAddrGray_out, 0);
    chk("clr_rd_gray", bus_if.RdAddrGray_out, 0);
    chk("clr_empty", bus_if.Empty_out, 1);
    chk("clr_almost_empty", bus_if.AlmostEmpty_out, 1);
    chk("clr_full", bus_if.Full_out, 0);
    chk("clr_almost_full", bus_if.AlmostFull_out, 0);
    chk("clr_overflow", bus_if.Overflow_out, 0);
    chk("clr_underflow", bus_if.Underflow_out, 0);
    $display("[TB] clear mid-op level=%0d empty=%0b", bus_if.Level_out, bus_if.Empty_out);

    // Read on empty after clear: rejected, underflow set.
    step(0, 0, 1);
    chk("post_clr_underflow", bus_if.Underflow_out, 1);
    chk("post_clr_rd_gray", bus_if.RdAddrGray_out, 0);
    $display("[TB] read on empty underflow=%0b", bus_if.Underflow_out);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
